// File: rtl/custom7_sequencer.sv
// 3-bit code sequencer for a custom 7-segment decoder: manual stepping from a
// debounced button, or automatic stepping from a prescaler, with load and hold.
module custom7_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TICK_DIV        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_step,
    input  logic       dir,
    input  logic       mode_sel,
    input  logic       hold,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       stepped,
    output logic [1:0] mode_state
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        HOLD   = 2'b10
    } mode_t;

    mode_t            state;
    mode_t            state_nx;

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_nx;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] db_cnt_nx;
    logic             btn_evt;

    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] presc_nx;
    logic             tick;
    logic             advance;
    logic [2:0]       code;
    logic [2:0]       code_nx;
    logic             stepped_nx;

    // Commit on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, so the
    // step event lands on the same edge the debounced level rises.
    always_comb begin
        deb_nx    = deb;
        db_cnt_nx = '0;
        btn_evt   = 1'b0;
        if (sync2 != deb) begin
            if (db_cnt == DB_LAST) begin
                deb_nx  = sync2;
                btn_evt = sync2;
            end else begin
                db_cnt_nx = db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = MANUAL;
        if (mode_sel) begin
            state_nx = hold ? HOLD : AUTO;
        end
    end

    always_comb begin
        tick       = (state == AUTO) && (presc == PRE_LAST);
        presc_nx   = '0;
        advance    = 1'b0;
        code_nx    = code;
        stepped_nx = 1'b0;

        unique case (state)
            AUTO:    presc_nx = tick ? '0 : presc + 1'b1;
            HOLD:    presc_nx = presc;
            default: presc_nx = '0;
        endcase

        // A tick only exists in AUTO and button events only count in MANUAL,
        // so at most one advance per cycle.
        advance = tick || (btn_evt && (state == MANUAL));
        if (advance) begin
            code_nx    = dir ? code + 3'd1 : code - 3'd1;
            stepped_nx = 1'b1;
        end

        if (load) begin
            code_nx    = load_val;
            presc_nx   = '0;
            stepped_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            db_cnt  <= '0;
            state   <= MANUAL;
            presc   <= '0;
            code    <= '0;
            stepped <= 1'b0;
        end else begin
            sync1   <= btn_step;
            sync2   <= sync1;
            deb     <= deb_nx;
            db_cnt  <= db_cnt_nx;
            state   <= state_nx;
            presc   <= presc_nx;
            code    <= code_nx;
            stepped <= stepped_nx;
        end
    end

    assign c0         = code[0];
    assign c1         = code[1];
    assign c2         = code[2];
    assign mode_state = state;

endmodule

// File: tb/tb_custom7_sequencer.sv
// Scoreboard bench for custom7_sequencer: stimulus queues expected per-edge
// snapshots and expected stepped pulses; a monitor checks them after each edge.
module tb_custom7_sequencer;

    localparam logic [1:0] M = 2'b00;
    localparam logic [1:0] A = 2'b01;
    localparam logic [1:0] H = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_step;
    logic       dir;
    logic       mode_sel;
    logic       hold;
    logic       load;
    logic [2:0] load_val;
    logic       c0;
    logic       c1;
    logic       c2;
    logic       stepped;
    logic [1:0] mode_state;

    custom7_sequencer #(.DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .dir        (dir),
        .mode_sel   (mode_sel),
        .hold       (hold),
        .load       (load),
        .load_val   (load_val),
        .c0         (c0),
        .c1         (c1),
        .c2         (c2),
        .stepped    (stepped),
        .mode_state (mode_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  code;
        logic        stp;
        logic [1:0]  st;
    } exp_t;

    exp_t        tq[$];
    logic [2:0]  pq[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (stepped === 1'b1) begin
            checks++;
            if (pq.size() == 0) begin
                $display("FAIL spurious_stepped @%0d code=%0d got stepped=1 required no pulse", cyc, {c2, c1, c0});
            end else begin
                logic [2:0] pe;
                pe = pq.pop_front();
                if ({c2, c1, c0} === pe) passes++;
                else $display("FAIL stepped_code @%0d got code=%0d required code=%0d", cyc, {c2, c1, c0}, pe);
            end
        end
        while (tq.size() > 0 && tq[0].cyc <= cyc) begin
            exp_t e;
            e = tq.pop_front();
            checks++;
            if (e.cyc == cyc && {c2, c1, c0} === e.code && stepped === e.stp && mode_state === e.st)
                passes++;
            else
                $display("FAIL snapshot @%0d got code=%0d stepped=%0b mode=%0d required @%0d code=%0d stepped=%0b mode=%0d",
                         cyc, {c2, c1, c0}, stepped, mode_state, e.cyc, e.code, e.stp, e.st);
        end
    end

    task automatic wait_n(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_seg(input int unsigned k0, input int unsigned k1,
                           input logic [2:0] c, input logic [1:0] s);
        for (int unsigned k = k0; k <= k1; k++) begin
            exp_t e;
            e.cyc = cyc + k; e.code = c; e.stp = 1'b0; e.st = s;
            tq.push_back(e);
        end
    endtask

    task automatic exp_step(input int unsigned k, input logic [2:0] c, input logic [1:0] s);
        exp_t e;
        e.cyc = cyc + k; e.code = c; e.stp = 1'b1; e.st = s;
        tq.push_back(e);
        pq.push_back(c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; btn_step = 1'b0; dir = 1'b1; mode_sel = 1'b0; hold = 1'b0;
        load = 1'b1; load_val = 3'd5;
        wait_n(1);
        // reset wins over a coincident load
        exp_seg(1, 2, 3'd0, M);
        wait_n(2);

        // manual step up from 3: change on edge 6
        rst = 1'b0; load = 1'b1; load_val = 3'd3;
        exp_seg(1, 1, 3'd3, M);
        wait_n(1);
        load = 1'b0; btn_step = 1'b1; dir = 1'b1;
        exp_seg(1, 5, 3'd3, M); exp_step(6, 3'd4, M); exp_seg(7, 18, 3'd4, M);
        wait_n(10);
        btn_step = 1'b0;
        wait_n(8);

        // bounce: never four consecutive highs
        exp_seg(1, 20, 3'd4, M);
        for (int i = 0; i < 12; i++) begin
            btn_step = (i % 3) != 2;
            wait_n(1);
        end
        btn_step = 1'b0;
        wait_n(8);

        // manual step down
        dir = 1'b0; btn_step = 1'b1;
        exp_seg(1, 5, 3'd4, M); exp_step(6, 3'd3, M); exp_seg(7, 8, 3'd3, M);
        wait_n(8);
        btn_step = 1'b0;
        exp_seg(1, 8, 3'd3, M);
        wait_n(8);

        // auto wrap up then down
        load = 1'b1; load_val = 3'd6; dir = 1'b1;
        exp_seg(1, 1, 3'd6, M);
        wait_n(1);
        load = 1'b0; mode_sel = 1'b1;
        exp_seg(1, 5, 3'd6, A); exp_step(6, 3'd7, A); exp_seg(7, 10, 3'd7, A);
        exp_step(11, 3'd0, A); exp_seg(12, 15, 3'd0, A); exp_step(16, 3'd1, A);
        wait_n(16);
        dir = 1'b0;
        exp_seg(1, 4, 3'd1, A); exp_step(5, 3'd0, A); exp_seg(6, 9, 3'd0, A); exp_step(10, 3'd7, A);
        wait_n(10);

        // hold with prescaler frozen at 2, resume ticks 3 edges later
        load = 1'b1; load_val = 3'd2;
        exp_seg(1, 2, 3'd2, A); exp_seg(3, 22, 3'd2, H); exp_seg(23, 25, 3'd2, A); exp_step(26, 3'd1, A);
        wait_n(1);
        load = 1'b0;
        wait_n(1);
        hold = 1'b1;
        wait_n(20);
        hold = 1'b0;
        wait_n(4);

        // load coincident with tick, button ignored in AUTO
        btn_step = 1'b1;
        exp_seg(1, 4, 3'd1, A); exp_seg(5, 9, 3'd5, A); exp_step(10, 3'd4, A);
        wait_n(4);
        load = 1'b1; load_val = 3'd5;
        wait_n(1);
        load = 1'b0;
        wait_n(5);
        mode_sel = 1'b0; btn_step = 1'b0;
        exp_seg(1, 8, 3'd4, M);
        wait_n(8);

        // reset mid-debounce with button held through release
        load = 1'b1; load_val = 3'd2; dir = 1'b1;
        exp_seg(1, 1, 3'd2, M);
        wait_n(1);
        load = 1'b0; btn_step = 1'b1;
        exp_seg(1, 3, 3'd2, M); exp_seg(4, 9, 3'd0, M); exp_step(10, 3'd1, M); exp_seg(11, 13, 3'd1, M);
        wait_n(3);
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        wait_n(13);
        btn_step = 1'b0;
        wait_n(2);

        checks++;
        if (pq.size() == 0 && tq.size() == 0) passes++;
        else $display("FAIL leftovers got pulses=%0d snapshots=%0d required 0/0", pq.size(), tq.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
